// File: rtl/mlp_collector.sv
// rtl/mlp_collector.sv - receive-side AXI-Stream collector for an MLP NoC node
module mlp_collector #(
  parameter int DATAW     = 512,
  parameter int BYTEW     = 8,
  parameter int IDW       = 32,
  parameter int DESTW     = 7,
  parameter int USERW     = 75,
  parameter int DATAUSERW = DATAW + USERW,
  parameter int NODE_ID   = 0,
  parameter int MSG_TYPE  = 2,
  parameter int DEPTH     = 8,
  parameter int MAX_BEATS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axis_rx_tvalid,
  input  logic [DATAUSERW-1:0] axis_rx_tdata,
  input  logic [BYTEW-1:0]     axis_rx_tstrb,
  input  logic [BYTEW-1:0]     axis_rx_tkeep,
  input  logic [IDW-1:0]       axis_rx_tid,
  input  logic [DESTW-1:0]     axis_rx_tdest,
  input  logic [USERW-1:0]     axis_rx_tuser,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  output logic                 out_valid,
  output logic [DATAW-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [15:0]          pkt_count,
  output logic                 err_dest,
  output logic                 err_type,
  output logic                 err_len
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int BCW  = $clog2(MAX_BEATS + 1);

  // DROP swallows the tail of a packet that was cut short by the length limit
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t              state, state_n;
  logic [BCW-1:0]      beat_cnt, beat_cnt_n;
  logic [DATAW:0]      mem [DEPTH];
  logic [PTRW-1:0]     wr_ptr, rd_ptr;
  logic [CNTW-1:0]     mem_cnt, mem_cnt_n, occ_n;
  logic                out_valid_n;

  logic                accept, dest_ok, type_ok, good;
  logic                push, push_last, set_len, pkt_done, load;
  logic [DATAW-1:0]    payload;
  logic [1:0]          msg_type;

  // Sideband fields are carried but never interpreted here
  logic unused_inputs;
  assign unused_inputs = ^{axis_rx_tdata[DATAUSERW-1:DATAW+11], axis_rx_tdata[DATAW+8:DATAW],
                           axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid, axis_rx_tuser};

  assign accept   = axis_rx_tvalid & axis_rx_tready;
  assign payload  = axis_rx_tdata[DATAW-1:0];
  assign msg_type = axis_rx_tdata[DATAW+10:DATAW+9];
  assign dest_ok  = (axis_rx_tdest == DESTW'(NODE_ID));
  assign type_ok  = (msg_type == 2'(MSG_TYPE));
  assign good     = dest_ok & type_ok;

  // Packet framing: decide what to store, when a packet closes and when the length limit trips
  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    push       = 1'b0;
    push_last  = 1'b0;
    set_len    = 1'b0;
    pkt_done   = 1'b0;
    if (accept) begin
      case (state)
        IDLE, RECV: begin
          if (good) begin
            push = 1'b1;
            if (axis_rx_tlast) begin
              push_last  = 1'b1;
              pkt_done   = 1'b1;
              state_n    = IDLE;
              beat_cnt_n = '0;
            end else if (beat_cnt == BCW'(MAX_BEATS - 1)) begin
              push_last  = 1'b1;
              set_len    = 1'b1;
              state_n    = DROP;
              beat_cnt_n = beat_cnt + 1'b1;
            end else begin
              state_n    = RECV;
              beat_cnt_n = beat_cnt + 1'b1;
            end
          end else if (axis_rx_tlast) begin
            pkt_done   = (state == RECV);
            state_n    = IDLE;
            beat_cnt_n = '0;
          end
        end
        DROP: begin
          if (axis_rx_tlast) begin
            pkt_done   = 1'b1;
            state_n    = IDLE;
            beat_cnt_n = '0;
          end
        end
        default: begin
          state_n    = IDLE;
          beat_cnt_n = '0;
        end
      endcase
    end
  end

  // The output register counts as one buffer slot, so occupancy spans memory plus out_valid
  always_comb begin
    load        = (mem_cnt != '0) && (!out_valid || out_ready);
    mem_cnt_n   = mem_cnt + CNTW'(push) - CNTW'(load);
    out_valid_n = load | (out_valid & ~out_ready);
    occ_n       = mem_cnt_n + CNTW'(out_valid_n);
  end

  // Framing state, status counters and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      pkt_count <= '0;
      err_dest  <= 1'b0;
      err_type  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      if (pkt_done) pkt_count <= pkt_count + 16'd1;
      if (accept && !dest_ok) err_dest <= 1'b1;
      if (accept && !type_ok) err_type <= 1'b1;
      if (set_len) err_len <= 1'b1;
    end
  end

  // Buffer storage, written without reset since occupancy alone defines valid entries
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, payload};
  end

  // Pointers, occupancy, registered ready and the registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      mem_cnt        <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      axis_rx_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr               <= rd_ptr + 1'b1;
        {out_last, out_data} <= mem[rd_ptr];
      end
      mem_cnt        <= mem_cnt_n;
      out_valid      <= out_valid_n;
      axis_rx_tready <= (occ_n != CNTW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_mlp_collector.sv
// tb/tb_mlp_collector.sv - randomized scoreboard bench for mlp_collector
module tb_mlp_collector;

  localparam int DATAW = 32;
  localparam int BYTEW = 8;
  localparam int IDW   = 32;
  localparam int DESTW = 7;
  localparam int USERW = 75;
  localparam int DUW   = DATAW + USERW;
  localparam int NODE  = 3;
  localparam int MSGT  = 2;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tvalid = 1'b0;
  logic [DUW-1:0]   tdata = '0;
  logic [BYTEW-1:0] tstrb = '0;
  logic [BYTEW-1:0] tkeep = '0;
  logic [IDW-1:0]   tid = '0;
  logic [DESTW-1:0] tdest = '0;
  logic [USERW-1:0] tuser = '0;
  logic             tlast = 1'b0;
  logic             tready;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic [15:0]      pkt_count;
  logic             err_dest, err_type, err_len;

  mlp_collector #(
    .DATAW(DATAW), .BYTEW(BYTEW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW), .DATAUSERW(DUW),
    .NODE_ID(NODE), .MSG_TYPE(MSGT), .DEPTH(DEPTH), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .axis_rx_tvalid(tvalid), .axis_rx_tdata(tdata), .axis_rx_tstrb(tstrb), .axis_rx_tkeep(tkeep),
    .axis_rx_tid(tid), .axis_rx_tdest(tdest), .axis_rx_tuser(tuser), .axis_rx_tlast(tlast),
    .axis_rx_tready(tready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_count(pkt_count), .err_dest(err_dest), .err_type(err_type), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: expected output beats {last, payload} and expected status
  logic [DATAW:0] exp_q[$];
  logic [15:0]    m_pkt = '0;
  bit             m_ed, m_et, m_el, m_drop;
  int             m_n;
  bit             armed;
  bit             stall_prev;
  logic [DATAW:0] prev_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_status", {tready, out_valid, out_last, err_dest, err_type, err_len, pkt_count}, '0);
      check("rst_data", out_data, '0);
      exp_q.delete();
      m_pkt = '0; m_ed = 0; m_et = 0; m_el = 0; m_drop = 0; m_n = 0; stall_prev = 0;
    end else begin
      check("pkt_count", pkt_count, m_pkt);
      check("err_flags", {err_dest, err_type, err_len}, {m_ed, m_et, m_el});
      if (armed) check("tready", tready, exp_q.size() != DEPTH);
      if (exp_q.size() == 0) check("idle_out_valid", out_valid, 1'b0);
      if (stall_prev) check("hold", {out_valid, out_last, out_data}, {1'b1, prev_out});
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", {out_last, out_data});
        end else begin
          check("out_beat", {out_last, out_data}, exp_q.pop_front());
        end
      end
      if (tvalid && tready) begin
        logic        dok, tok;
        logic [DATAW-1:0] pay;
        dok = (tdest == DESTW'(NODE));
        tok = (tdata[DATAW+10:DATAW+9] == 2'(MSGT));
        pay = tdata[DATAW-1:0];
        if (!dok) m_ed = 1;
        if (!tok) m_et = 1;
        if (m_drop) begin
          if (tlast) begin m_pkt++; m_drop = 0; m_n = 0; end
        end else if (dok && tok) begin
          m_n++;
          if (tlast) begin
            exp_q.push_back({1'b1, pay}); m_pkt++; m_n = 0;
          end else if (m_n == MAXB) begin
            exp_q.push_back({1'b1, pay}); m_el = 1; m_drop = 1;
          end else begin
            exp_q.push_back({1'b0, pay});
          end
        end else if (tlast) begin
          if (m_n > 0) m_pkt++;
          m_n = 0;
        end
      end
    end
  end

  task automatic drive(input logic [DATAW-1:0] pay, input logic [DESTW-1:0] dest,
                       input logic [1:0] typ, input bit last);
    logic [USERW-1:0] tu;
    tu = USERW'({$urandom(), $urandom(), $urandom()});
    tu[10:9] = typ;
    tdata  = {tu, pay};
    tuser  = ~tu;
    tdest  = dest;
    tlast  = last;
    tid    = $urandom();
    tkeep  = BYTEW'($urandom());
    tstrb  = BYTEW'($urandom());
    tvalid = 1'b1;
  endtask

  task automatic send(input logic [DATAW-1:0] pay, input logic [DESTW-1:0] dest,
                      input logic [1:0] typ, input bit last);
    int w;
    drive(pay, dest, typ, last);
    w = 0;
    @(negedge clk);
    while (!tready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=tready_low expected=accept payload=%0h", pay);
    end
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, stalls;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("tready_before_edge", tready, 1'b0);
    @(posedge clk); #1;
    check("tready_after_edge", tready, 1'b1);

    // single 4-beat packet, first output one cycle after first accept
    out_ready = 1'b1;
    send(32'h11, NODE, MSGT, 0);
    check("first_valid_early", out_valid, 1'b0);
    send(32'h12, NODE, MSGT, 0);
    check("first_valid", {out_valid, out_data}, {1'b1, 32'h11});
    send(32'h13, NODE, MSGT, 0);
    send(32'h14, NODE, MSGT, 1);
    idle(6);
    check("pkt_after_4beat", pkt_count, 16'd1);
    check("no_errors", {err_dest, err_type, err_len}, 3'b000);

    // back-pressure: 8 accepts fill the buffer
    out_ready = 1'b0;
    i = 0; stalls = 0;
    while (i < 10 && stalls < 4) begin
      drive(32'h100 + i, NODE, MSGT, 1);
      @(negedge clk);
      if (tready) i++; else stalls++;
      @(posedge clk); #1;
    end
    check("accepts_before_full", i, 8);
    out_ready = 1'b1;
    while (i < 10) begin
      send(32'h100 + i, NODE, MSGT, 1);
      i++;
    end
    idle(20);
    check("pkt_after_fill", pkt_count, 16'd11);

    // wrong destination inside a 3-beat packet
    send(32'h21, NODE, MSGT, 0);
    send(32'h22, 7'd5, MSGT, 0);
    send(32'h23, NODE, MSGT, 1);
    idle(8);
    check("err_dest", err_dest, 1'b1);
    check("pkt_after_dest", pkt_count, 16'd12);

    // wrong type on a single-beat packet
    send(32'h31, NODE, 2'h1, 1);
    idle(5);
    check("err_type", err_type, 1'b1);
    check("pkt_after_type", pkt_count, 16'd12);

    // over-length packet, then a normal one
    for (int k = 0; k < 6; k++) send(32'h40 + k, NODE, MSGT, k == 5);
    send(32'h50, NODE, MSGT, 0);
    send(32'h51, NODE, MSGT, 1);
    idle(10);
    check("err_len", err_len, 1'b1);
    check("pkt_after_len", pkt_count, 16'd14);

    // asynchronous reset with 5 beats buffered, mid-packet
    out_ready = 1'b0;
    send(32'h60, NODE, MSGT, 0);
    send(32'h61, NODE, MSGT, 1);
    for (int k = 0; k < 3; k++) send(32'h62 + k, NODE, MSGT, 0);
    #3 rst = 1'b0;
    #1 check("async_rst_status", {out_valid, out_last, tready, err_dest, err_type, err_len, pkt_count}, '0);
    check("async_rst_data", out_data, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h71, NODE, MSGT, 0);
    send(32'h72, NODE, MSGT, 1);
    idle(6);
    check("pkt_after_reset", pkt_count, 16'd1);
    check("errors_after_reset", {err_dest, err_type, err_len}, 3'b000);

    // randomized traffic with random back-pressure
    repeat (2000) begin
      if ($urandom_range(0, 9) < 7)
        drive($urandom(),
              ($urandom_range(0, 15) == 0) ? 7'd5 : 7'(NODE),
              ($urandom_range(0, 15) == 0) ? 2'h1 : 2'(MSGT),
              $urandom_range(0, 3) == 0);
      else
        tvalid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idle(30);
    check("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_collector.md
Name: mlp_collector

Overview:
- Receive-side AXI-Stream endpoint of an MLP NoC node. It accepts flits whose tdata is packed as {tuser, payload}, checks the destination and message type, and strips tuser.
- Valid payload beats go into a DEPTH-entry buffer. They are presented to the local compute stage through a valid/ready interface with packet framing.
- It also tracks packet state, beat counts and sticky error flags for debug.

Parameters:
- DATAW, 512, payload width.
- BYTEW, 8, tkeep/tstrb width.
- IDW, 32, tid width.
- DESTW, 7, tdest width.
- USERW, 75, tuser width.
- DATAUSERW, DATAW+USERW, packed flit width.
- NODE_ID, 0, this node's NoC address; compared against tdest.
- MSG_TYPE, 2, expected 2-bit type at tuser[10:9].
- DEPTH, 8, buffer entries; power of two, at least 2.
- MAX_BEATS, 256, maximum beats per packet.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- axis_rx_tvalid  in  1  flit valid.
- axis_rx_tdata  in  DATAUSERW  {tuser, payload}.
- axis_rx_tstrb  in  BYTEW  ignored.
- axis_rx_tkeep  in  BYTEW  ignored.
- axis_rx_tid  in  IDW  ignored.
- axis_rx_tdest  in  DESTW  destination node.
- axis_rx_tuser  in  USERW  ignored; the tuser copy inside tdata is authoritative.
- axis_rx_tlast  in  1  last beat of packet.
- axis_rx_tready  out  1  collector can accept a flit.
- out_valid  out  1  out_data valid.
- out_data  out  DATAW  payload.
- out_last  out  1  final beat of packet.
- out_ready  in  1  consumer accepts.
- pkt_count  out  16  completed packets, wraps.
- err_dest  out  1  sticky: tdest mismatch seen.
- err_type  out  1  sticky: type mismatch seen.
- err_len  out  1  sticky: packet exceeded MAX_BEATS.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0: axis_rx_tready=0, out_valid=0, out_data=0, out_last=0, pkt_count=0, all error flags 0.
  - Buffer is emptied and the state machine returns to IDLE.
  - A mid-packet reset discards buffered data; no partial packet survives.
  - axis_rx_tready stays 0 until the first clk edge after reset deasserts.
- Handshake and acceptance:
  - axis_rx_tready = ~full, registered.
  - A flit is accepted when tvalid & tready.
  - A pop in the same cycle does not free space for a push in that cycle (no bypass when full).
- Field extraction:
  - payload = tdata[DATAW-1:0].
  - type = tdata[DATAW+10:DATAW+9].
- Filtering of accepted flits:
  - An accepted flit is pushed only if tdest==NODE_ID and type==MSG_TYPE.
  - Otherwise it is consumed and dropped, and err_dest and/or err_type is set. Error flags clear only on reset.
  - A dropped flit carrying tlast still closes the packet. If no beat of that packet was pushed, nothing is emitted for it.
- State machine:
  - IDLE: a good accepted beat with tlast=0 goes to RECV with beat_cnt=1. A single-beat packet (tlast=1) stays in IDLE.
  - RECV: each accepted beat increments beat_cnt. A tlast beat returns to IDLE.
  - Packet completion: on any accepted tlast beat, pkt_count increments (modulo 2^16) if at least one beat of the packet was pushed.
- Length check:
  - When beat_cnt reaches MAX_BEATS and the accepted beat has tlast=0, err_len is set.
  - That beat is stored with out_last=1, forcing packet closure.
  - Further beats of the same packet are dropped until tlast, and the state returns to IDLE on that tlast.
- Buffer:
  - Circular, with pointer wrap at DEPTH. Each entry stores {last, payload}.
  - Output is registered: a beat accepted at edge N appears on out_valid/out_data at edge N+1 at the earliest.
  - Order is preserved. Full throughput is 1 beat/cycle when out_ready=1 and the buffer is not full.
  - Full: count==DEPTH. Empty: count==0.
  - Simultaneous push and pop on a non-full buffer leave count unchanged.
- Output stability: out_data and out_last hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Single 4-beat packet, NODE_ID=3, tdest=3, type=2, payloads 0x11..0x14, out_ready=1 -> out beats 0x11..0x14 in order, out_last only on 0x14, first out_valid 1 cycle after first accept, pkt_count=1, no errors.
- out_ready=0, stream 10 good beats -> tready drops after 8 accepts (DEPTH=8); release out_ready -> all 10 emerge in order, pointers wrap, no loss or duplication.
- Beat with tdest=5 in a 3-beat packet -> beat dropped, err_dest=1 (sticky), other 2 beats emitted, last of those has out_last=1, pkt_count=1.
- Type field 2'h1 on a single-beat tlast packet -> nothing emitted, err_type=1, pkt_count unchanged, state IDLE.
- MAX_BEATS=4, 6-beat packet -> beats 1-4 emitted with out_last on beat 4, beats 5-6 dropped, err_len=1, next packet received normally.
- Assert rst=0 asynchronously mid-packet with 5 beats buffered -> outputs 0 immediately, buffer empty; after release, a new 2-beat packet passes cleanly and pkt_count=1.
